instr_fetch_unit: RTL and testbench

- Fetch-side initiator for the single-port instruction RAM.
- Generates sequential word reads and absorbs the RAM's fixed one-cycle read latency in a small prefetch FIFO.
- Presents instructions to the core decode stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch from a one-cycle-latency RAM
// through a credit-limited prefetch FIFO, with branch redirect and flush.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_i,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    instr_valid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    input  logic                    instr_ready_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] fetch_pc, req_addr;
    logic [CW:0]           occ;
    logic                  pop, push, issue;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign mem_we_o    = 1'b0;
    assign mem_be_o    = '1;
    assign mem_wdata_o = '0;

    assign pop   = instr_valid_o & instr_ready_i;
    // Credits cover both buffered words and the word still returning from RAM.
    assign occ   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue = !rst_i && (occ < (CW+1)'(FIFO_DEPTH));

    assign mem_en_o   = !rst_i && (issue || branch_i);
    assign mem_addr_o = rst_i ? BOOT_ADDR :
                        branch_i ? (branch_addr_i & ~ADDR_WIDTH'(3)) : fetch_pc;

    // A response arriving in a branch cycle belongs to the old stream.
    assign push = inflight & !branch_i;

    assign instr_valid_o = !rst_i && (count != '0);
    assign instr_rdata_o = rst_i ? '0 : data_q[rd_ptr];
    assign instr_addr_o  = rst_i ? BOOT_ADDR : addr_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            fetch_pc <= BOOT_ADDR;
            req_addr <= BOOT_ADDR;
        end else begin
            inflight <= mem_en_o;
            if (mem_en_o) begin
                fetch_pc <= mem_addr_o + ADDR_WIDTH'(4);
                req_addr <= mem_addr_o;
            end
            if (branch_i) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= nxt(wr_ptr);
                if (pop) rd_ptr <= nxt(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_i && push) begin
            data_q[wr_ptr] <= mem_rdata_i;
            addr_q[wr_ptr] <= req_addr;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of sequential fetch, branch flush,
// address wrap, backpressure and mid-stream reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_en_o;
    logic [7:0]  mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [7:0]  instr_addr_o;
    logic        instr_ready_i;
    logic        branch_i;
    logic [7:0]  branch_addr_i;
    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_i(rst_i),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o), .instr_ready_i(instr_ready_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, word at A reads as 0x13000000|A.
    always @(posedge clk) if (mem_en_o) mem_rdata_i <= 32'h1300_0000 | {24'h0, mem_addr_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic head(input logic [7:0] a);
        chk("valid", {31'h0, instr_valid_o}, 32'h1);
        chk("instr_addr", {24'h0, instr_addr_o}, {24'h0, a});
        chk("instr_rdata", instr_rdata_o, 32'h1300_0000 | {24'h0, a});
    endtask

    task automatic empty();
        chk("valid_empty", {31'h0, instr_valid_o}, 32'h0);
    endtask

    task automatic req(input logic en, input logic [7:0] a);
        chk("mem_en", {31'h0, mem_en_o}, {31'h0, en});
        if (en) chk("mem_addr", {24'h0, mem_addr_o}, {24'h0, a});
    endtask

    task automatic in_reset();
        chk("rst_mem_en", {31'h0, mem_en_o}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr_o}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_rdata", instr_rdata_o, 32'h0);
        chk("rst_instr_addr", {24'h0, instr_addr_o}, 32'h0);
    endtask

    always @(negedge clk) begin
        chk("tie_we", {31'h0, mem_we_o}, 32'h0);
        chk("tie_be", {28'h0, mem_be_o}, 32'hF);
        chk("tie_wdata", mem_wdata_o, 32'h0);
        chk("addr_align", {30'h0, mem_addr_o[1:0]}, 32'h0);
    end

    initial begin
        rst_i = 1'b1; instr_ready_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
        tick(); tick();
        in_reset();
        // Sequential fetch from BOOT_ADDR
        rst_i = 1'b0; #1;
        req(1'b1, 8'h00); empty();
        tick(); req(1'b1, 8'h04); empty();
        tick(); head(8'h00);
        tick(); head(8'h04);
        tick(); head(8'h08); req(1'b1, 8'h10);
        // Branch while 0x10 is in flight; head 0x0C still delivered
        tick(); head(8'h0C);
        branch_i = 1'b1; branch_addr_i = 8'h43; #1;
        req(1'b1, 8'h40);
        tick(); branch_i = 1'b0; #1; empty();
        tick(); head(8'h40);
        tick(); head(8'h44);
        // Wrap-around branch
        tick(); head(8'h48);
        branch_i = 1'b1; branch_addr_i = 8'hF8; #1;
        req(1'b1, 8'hF8);
        tick(); branch_i = 1'b0; #1; empty();
        tick(); head(8'hF8);
        tick(); head(8'hFC);
        tick(); head(8'h00);
        tick(); head(8'h04);
        tick(); head(8'h08);
        // Backpressure fills the FIFO
        instr_ready_i = 1'b0; #1;
        req(1'b0, 8'h00);
        tick(); head(8'h08); req(1'b0, 8'h00);
        // Reset with FIFO full
        rst_i = 1'b1; #1;
        in_reset();
        tick(); rst_i = 1'b0; #1;
        req(1'b1, 8'h00); empty();
        tick(); req(1'b1, 8'h04); empty();
        tick(); head(8'h00); req(1'b0, 8'h00);
        tick(); head(8'h00); req(1'b0, 8'h00);
        tick(); head(8'h00);
        instr_ready_i = 1'b1; #1;
        req(1'b1, 8'h08); head(8'h00);
        tick(); head(8'h04);
        tick(); head(8'h08);
        tick(); head(8'h0C);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
